// File: rtl/ram_scan_dp.sv
// Simple-dual-port RAM with an independent write port and a self-advancing read pointer
// (auto-scan at a programmable rate, manual hold/step, or direct pointer load).
module ram_scan_dp #(
   parameter int unsigned DATA_W   = 4,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned TICK_DIV = 50000000
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              WrEn,
   input  logic [ADDR_W-1:0] WrAddr,
   input  logic [DATA_W-1:0] WrData,
   input  logic              ScanEn,
   input  logic              Step,
   input  logic              LdEn,
   input  logic [ADDR_W-1:0] LdAddr,
   output logic [ADDR_W-1:0] RdAddr,
   output logic [DATA_W-1:0] RdData,
   output logic              Tick
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              tick_q, tick_d;
   logic              term;

   // Array is deliberately not reset; writes are blocked while reset is held.
   always_ff @(posedge Clock) begin
      if (WrEn && Resetn) begin
         mem_q[WrAddr] <= WrData;
      end
   end

   assign term = ScanEn && (cnt_q == CNT_LAST);

   always_comb begin
      rd_addr_d = rd_addr_q;
      cnt_d     = '0;
      tick_d    = 1'b0;
      rd_data_d = (WrEn && (WrAddr == rd_addr_q)) ? WrData : mem_q[rd_addr_q];

      if (ScanEn && !term) begin
         cnt_d = cnt_q + 1'b1;
      end

      // A load wins over a coincident terminal count and restarts the divider.
      if (LdEn) begin
         rd_addr_d = LdAddr;
         cnt_d     = '0;
      end else if (term) begin
         rd_addr_d = rd_addr_q + 1'b1;
         tick_d    = 1'b1;
      end else if (!ScanEn && Step) begin
         rd_addr_d = rd_addr_q + 1'b1;
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         rd_addr_q <= '0;
         rd_data_q <= '0;
         cnt_q     <= '0;
         tick_q    <= 1'b0;
      end else begin
         rd_addr_q <= rd_addr_d;
         rd_data_q <= rd_data_d;
         cnt_q     <= cnt_d;
         tick_q    <= tick_d;
      end
   end

   assign RdAddr = rd_addr_q;
   assign RdData = rd_data_q;
   assign Tick   = tick_q;

endmodule

// File: tb/tb_ram_scan_dp.sv
// Scoreboard bench for ram_scan_dp: stimulus queues hand-computed expectations,
// a monitor pops and compares them at the falling edge (or on demand for async reset).
module tb_ram_scan_dp;

   logic       clk;
   logic       Resetn;
   logic       WrEn;
   logic [4:0] WrAddr;
   logic [3:0] WrData;
   logic       ScanEn;
   logic       Step;
   logic       LdEn;
   logic [4:0] LdAddr;
   logic [4:0] RdAddr;
   logic [3:0] RdData;
   logic       Tick;

   ram_scan_dp #(
      .DATA_W  (4),
      .ADDR_W  (5),
      .TICK_DIV(4)
   ) dut (
      .Clock (clk),
      .Resetn(Resetn),
      .WrEn  (WrEn),
      .WrAddr(WrAddr),
      .WrData(WrData),
      .ScanEn(ScanEn),
      .Step  (Step),
      .LdEn  (LdEn),
      .LdAddr(LdAddr),
      .RdAddr(RdAddr),
      .RdData(RdData),
      .Tick  (Tick)
   );

   typedef struct {
      string      name;
      int         tgt;
      logic [4:0] addr;
      logic [3:0] data;
      logic       tick;
      bit         cd;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   event smp;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   always begin
      @(negedge clk or smp);
      while (sb.size() > 0 && sb[0].tgt <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if (RdAddr !== e.addr || Tick !== e.tick || (e.cd && RdData !== e.data)) begin
            errors++;
            $display("FAIL %s (cyc %0d): got RdAddr=%0d Tick=%0b RdData=%h, want RdAddr=%0d Tick=%0b RdData=%h%s",
                     e.name, cyc, RdAddr, Tick, RdData, e.addr, e.tick, e.data, e.cd ? "" : " (data not checked)");
         end
      end
   end

   task automatic push(input string n, input int tgt, input int a, input int d, input bit t, input bit cd);
      exp_t e;
      e.name = n;
      e.tgt  = tgt;
      e.addr = 5'(a);
      e.data = 4'(d);
      e.tick = t;
      e.cd   = cd;
      sb.push_back(e);
   endtask

   // Expectation for the outputs after the next rising edge.
   task automatic expn(input string n, input int a, input int d, input bit t, input bit cd);
      push(n, cyc + 1, a, d, t, cd);
   endtask

   task automatic cyc1();
      @(negedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      Resetn = 1'b1;
      WrEn   = 1'b0;
      WrAddr = '0;
      WrData = '0;
      ScanEn = 1'b0;
      Step   = 1'b0;
      LdEn   = 1'b0;
      LdAddr = '0;
      #2 Resetn = 1'b0;
      #1;
      push("reset_init", cyc, 0, 0, 1'b0, 1'b1);
      ->smp;
      cyc1();
      cyc1();
      Resetn = 1'b1;

      for (int a = 0; a < 32; a++) begin
         WrEn   = 1'b1;
         WrAddr = 5'(a);
         WrData = 4'(a) ^ 4'hA;
         cyc1();
      end
      WrEn = 1'b0;

      // Auto-scan from 0 across the full array and through the wrap.
      LdEn   = 1'b1;
      LdAddr = 5'd0;
      ScanEn = 1'b1;
      expn("load0", 0, 'hA, 1'b0, 1'b1);
      cyc1();
      LdEn = 1'b0;
      for (int k = 1; k <= 132; k++) begin
         expn(k >= 128 ? "wrap" : "scan", (k / 4) % 32,
              int'(4'(((k - 1) / 4) % 32) ^ 4'hA), (k % 4) == 0, 1'b1);
         cyc1();
      end

      // Manual stepping from 5.
      ScanEn = 1'b0;
      LdEn   = 1'b1;
      LdAddr = 5'd5;
      expn("ld5", 5, 0, 1'b0, 1'b0);
      cyc1();
      LdEn = 1'b0;
      Step = 1'b1; expn("step_a", 6, 'hF, 1'b0, 1'b1); cyc1();
      Step = 1'b0; expn("gap_a",  6, 'hC, 1'b0, 1'b1); cyc1();
      Step = 1'b1; expn("step_b", 7, 'hC, 1'b0, 1'b1); cyc1();
      Step = 1'b0; expn("gap_b",  7, 'hD, 1'b0, 1'b1); cyc1();
      Step = 1'b1; expn("step_c", 8, 'hD, 1'b0, 1'b1); cyc1();

      // Step ignored in scan mode; first advance TICK_DIV edges after enabling.
      ScanEn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         expn("step_in_scan", 8, 'h2, 1'b0, 1'b1);
         cyc1();
      end
      Step = 1'b0;
      expn("scan_restart", 9, 'h2, 1'b1, 1'b1);
      cyc1();

      // Read-during-write bypass.
      ScanEn = 1'b0;
      LdEn   = 1'b1;
      LdAddr = 5'd7;
      expn("ld7", 7, 0, 1'b0, 1'b0);
      cyc1();
      LdEn   = 1'b0;
      WrEn   = 1'b1;
      WrAddr = 5'd7;
      WrData = 4'h3;
      expn("bypass", 7, 'h3, 1'b0, 1'b1);
      cyc1();
      WrAddr = 5'd9;
      WrData = 4'h5;
      expn("write_other", 7, 'h3, 1'b0, 1'b1);
      cyc1();
      WrEn = 1'b0;
      expn("hold7", 7, 'h3, 1'b0, 1'b1);
      cyc1();

      // Load coincident with terminal count.
      ScanEn = 1'b1;
      LdEn   = 1'b1;
      LdAddr = 5'd17;
      expn("ld17", 17, 0, 1'b0, 1'b0);
      cyc1();
      LdEn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         expn("count17", 17, 'hB, 1'b0, 1'b1);
         cyc1();
      end
      LdEn   = 1'b1;
      LdAddr = 5'd20;
      expn("ld_vs_tc", 20, 'hB, 1'b0, 1'b1);
      cyc1();
      LdEn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         expn("restart20", 20, 'hE, 1'b0, 1'b1);
         cyc1();
      end
      expn("adv21", 21, 'hE, 1'b1, 1'b1);
      cyc1();

      // Async reset between edges while Tick is high; write during reset is ignored.
      #1;
      Resetn = 1'b0;
      WrEn   = 1'b1;
      WrAddr = 5'd0;
      WrData = 4'h0;
      #1;
      push("reset_async", cyc, 0, 0, 1'b0, 1'b1);
      ->smp;
      #1;
      expn("reset_hold", 0, 0, 1'b0, 1'b1);
      cyc1();
      Resetn = 1'b1;
      WrEn   = 1'b0;
      ScanEn = 1'b0;
      expn("post_reset", 0, 'hA, 1'b0, 1'b1);
      cyc1();
      expn("post_reset_idle", 0, 'hA, 1'b0, 1'b1);
      cyc1();
      cyc1();

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
